// File: rtl/mat_addsub_seq.sv
// Sequential N x N matrix add/subtract, LANES elements per cycle, with
// optional saturation and a sticky overflow flag.
module mat_addsub_seq #(
    parameter int W     = 26,
    parameter int N     = 4,
    parameter int LANES = 4
) (
    input  logic             clk_sub,
    input  logic             rstn_sub,
    input  logic             start_sub,
    input  logic             clr_sub,
    input  logic             mode_sub,
    input  logic             sat_en,
    input  logic [N*N*W-1:0] a_flat,
    input  logic [N*N*W-1:0] b_flat,
    output logic [N*N*W-1:0] w_flat,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    localparam int K  = N * N / LANES;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt;
    logic [N*N*W-1:0] a_q;
    logic [N*N*W-1:0] b_q;
    logic             mode_q;
    logic             sat_q;
    logic             load;
    logic             step;
    logic             last;

    logic [W-1:0]     a_g [K][LANES];
    logic [W-1:0]     b_g [K][LANES];
    logic [W-1:0]     w_q [K][LANES];
    logic [W:0]       sum [LANES];
    logic [W-1:0]     res [LANES];
    logic [LANES-1:0] lane_ovf;

    // Group-indexed views of the captured operands and of the result store.
    for (genvar k = 0; k < K; k++) begin : g_grp
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            assign a_g[k][l] = a_q[(k*LANES+l)*W +: W];
            assign b_g[k][l] = b_q[(k*LANES+l)*W +: W];
            assign w_flat[(k*LANES+l)*W +: W] = w_q[k][l];
        end
    end

    always_ff @(posedge clk_sub or negedge rstn_sub) begin
        if (!rstn_sub) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = RUN;
            RUN:     if (clr_sub || last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // clr_sub outranks both a new start and a pending RUN step.
    always_comb begin
        busy = (state_q == RUN);
        load = (state_q == IDLE) && start_sub && !clr_sub;
        step = (state_q == RUN) && !clr_sub;
        last = step && (cnt == CW'(K - 1));
    end

    // One guard bit catches overflow: it shows up as sum[W] != sum[W-1].
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            if (mode_q) begin
                sum[l] = {a_g[cnt][l][W-1], a_g[cnt][l]} + {b_g[cnt][l][W-1], b_g[cnt][l]};
            end else begin
                sum[l] = {a_g[cnt][l][W-1], a_g[cnt][l]} - {b_g[cnt][l][W-1], b_g[cnt][l]};
            end
            lane_ovf[l] = sum[l][W] ^ sum[l][W-1];
            if (lane_ovf[l] && sat_q) begin
                res[l] = sum[l][W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end else begin
                res[l] = sum[l][W-1:0];
            end
        end
    end

    always_ff @(posedge clk_sub or negedge rstn_sub) begin
        if (!rstn_sub) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            sat_q  <= 1'b0;
            cnt    <= '0;
            ovf    <= 1'b0;
            done   <= 1'b0;
            for (int k = 0; k < K; k++) begin
                for (int l = 0; l < LANES; l++) begin
                    w_q[k][l] <= '0;
                end
            end
        end else begin
            done <= last;
            if (load) begin
                a_q    <= a_flat;
                b_q    <= b_flat;
                mode_q <= mode_sub;
                sat_q  <= sat_en;
                cnt    <= '0;
                ovf    <= 1'b0;
            end else if (step) begin
                for (int l = 0; l < LANES; l++) begin
                    w_q[cnt][l] <= res[l];
                end
                ovf <= ovf | (|lane_ovf);
                cnt <= last ? '0 : cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mat_addsub_seq.sv
// Self-checking bench for mat_addsub_seq: element-level arithmetic model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_mat_addsub_seq;

    localparam int W     = 26;
    localparam int N     = 4;
    localparam int LANES = 4;
    localparam int K     = N * N / LANES;
    localparam int NE    = N * N;
    localparam int NW    = N * N * W;
    localparam longint MAXV = (64'sd1 <<< (W - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (W - 1));

    logic          clk_sub = 1'b0;
    logic          rstn_sub;
    logic          start_sub;
    logic          clr_sub;
    logic          mode_sub;
    logic          sat_en;
    logic [NW-1:0] a_flat;
    logic [NW-1:0] b_flat;
    logic [NW-1:0] w_flat;
    logic          busy;
    logic          done;
    logic          ovf;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    longint        m_res  [NE];
    bit            m_rovf [NE];
    longint        m_w    [NE];
    bit            m_busy;
    bit            m_done;
    bit            m_ovf;
    int            m_grp;
    logic [NW-1:0] exp_w;

    always #5 clk_sub = ~clk_sub;

    mat_addsub_seq #(.W(W), .N(N), .LANES(LANES)) dut (
        .clk_sub   (clk_sub),
        .rstn_sub  (rstn_sub),
        .start_sub (start_sub),
        .clr_sub   (clr_sub),
        .mode_sub  (mode_sub),
        .sat_en    (sat_en),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .w_flat    (w_flat),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf)
    );

    function automatic longint el(input logic [NW-1:0] v, input int e);
        logic [W-1:0] x;
        x = v[e*W +: W];
        return longint'($signed(x));
    endfunction

    function automatic logic [NW-1:0] put(input logic [NW-1:0] v, input int e, input longint x);
        logic [NW-1:0] r;
        r = v;
        r[e*W +: W] = x[W-1:0];
        return r;
    endfunction

    function automatic logic [NW-1:0] fill(input longint x);
        logic [NW-1:0] r;
        r = '0;
        for (int e = 0; e < NE; e++) r[e*W +: W] = x[W-1:0];
        return r;
    endfunction

    // Exact-integer arithmetic, then range check, clamp or wrap by 2^W.
    function automatic void arith(input longint a, input longint b, input bit md, input bit st,
                                  output longint r, output bit o);
        longint s;
        s = md ? a + b : a - b;
        o = (s > MAXV) || (s < MINV);
        if (!o)      r = s;
        else if (st) r = (s > MAXV) ? MAXV : MINV;
        else         r = (s > MAXV) ? s - (64'sd1 <<< W) : s + (64'sd1 <<< W);
    endfunction

    always @(posedge clk_sub or negedge rstn_sub) begin
        if (!rstn_sub) begin
            for (int e = 0; e < NE; e++) m_w[e] = 0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_ovf  = 1'b0;
            m_grp  = 0;
        end else begin
            m_done = 1'b0;
            if (clr_sub) begin
                m_busy = 1'b0;
            end else if (!m_busy) begin
                if (start_sub) begin
                    for (int e = 0; e < NE; e++)
                        arith(el(a_flat, e), el(b_flat, e), mode_sub, sat_en, m_res[e], m_rovf[e]);
                    m_busy = 1'b1;
                    m_ovf  = 1'b0;
                    m_grp  = 0;
                end
            end else begin
                for (int l = 0; l < LANES; l++) begin
                    m_w[m_grp*LANES+l] = m_res[m_grp*LANES+l];
                    if (m_rovf[m_grp*LANES+l]) m_ovf = 1'b1;
                end
                m_grp++;
                if (m_grp == K) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string nm, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", nm, actual, expected);
        end
    endtask

    task automatic checkVec(input string nm, input logic [NW-1:0] actual, input logic [NW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", nm, actual, expected);
        end
    endtask

    always @(negedge clk_sub) begin
        if (chk_en && rstn_sub) begin
            for (int e = 0; e < NE; e++) exp_w[e*W +: W] = m_w[e][W-1:0];
            checkVec("cyc_w_flat", w_flat, exp_w);
            checkOutput("cyc_busy", longint'(busy), longint'(m_busy));
            checkOutput("cyc_done", longint'(done), longint'(m_done));
            checkOutput("cyc_ovf", longint'(ovf), longint'(m_ovf));
        end
    end

    task automatic tick();
        @(negedge clk_sub);
    endtask

    task automatic applyStimulus(input logic [NW-1:0] a, input logic [NW-1:0] b, input logic md, input logic st);
        a_flat    = a;
        b_flat    = b;
        mode_sub  = md;
        sat_en    = st;
        start_sub = 1'b1;
        tick();
        start_sub = 1'b0;
    endtask

    task automatic waitDone(input int exp_lat, input string nm);
        int busy_cycles;
        int lat;
        busy_cycles = int'(busy);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
            busy_cycles += int'(busy);
        end
        checkOutput({nm, "_done_latency"}, lat, exp_lat);
        checkOutput({nm, "_busy_cycles"}, busy_cycles, exp_lat);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int extra;
        rstn_sub  = 1'b0;
        start_sub = 1'b0;
        clr_sub   = 1'b0;
        mode_sub  = 1'b0;
        sat_en    = 1'b0;
        a_flat    = '0;
        b_flat    = '0;
        repeat (2) tick();
        checkVec("rst_w", w_flat, '0);
        checkOutput("rst_busy", longint'(busy), 0);
        checkOutput("rst_done", longint'(done), 0);
        checkOutput("rst_ovf", longint'(ovf), 0);
        rstn_sub = 1'b1;
        chk_en   = 1'b1;
        tick();

        $display("[TB] subtract 100-30");
        applyStimulus(fill(100), fill(30), 1'b0, 1'b0);
        waitDone(4, "sub");
        checkOutput("sub_w00", el(w_flat, 0), 70);
        checkOutput("sub_w33", el(w_flat, 15), 70);
        checkOutput("sub_ovf", longint'(ovf), 0);
        tick();
        checkOutput("sub_done_drop", longint'(done), 0);

        $display("[TB] positive overflow, saturate then wrap");
        applyStimulus(put('0, 0, MAXV), put('0, 0, 1), 1'b1, 1'b1);
        waitDone(4, "addsat");
        checkOutput("addsat_w00", el(w_flat, 0), 33554431);
        checkOutput("addsat_w01", el(w_flat, 1), 0);
        checkOutput("addsat_ovf", longint'(ovf), 1);
        applyStimulus(put('0, 0, MAXV), put('0, 0, 1), 1'b1, 1'b0);
        waitDone(4, "addwrap");
        checkOutput("addwrap_w00", el(w_flat, 0), -33554432);
        checkOutput("addwrap_ovf", longint'(ovf), 1);

        $display("[TB] negative saturation");
        applyStimulus(put('0, 15, MINV), put('0, 15, 1), 1'b0, 1'b1);
        waitDone(4, "negsat");
        checkOutput("negsat_w33", el(w_flat, 15), -33554432);
        checkOutput("negsat_w00", el(w_flat, 0), 0);
        checkOutput("negsat_ovf", longint'(ovf), 1);

        $display("[TB] ignored start and operand change");
        applyStimulus(fill(500), fill(7), 1'b1, 1'b0);
        start_sub = 1'b1;
        a_flat    = fill(9);
        mode_sub  = 1'b0;
        tick();
        start_sub = 1'b0;
        waitDone(3, "ign");
        checkOutput("ign_w12", el(w_flat, 6), 507);
        checkOutput("ign_ovf", longint'(ovf), 0);
        extra = 0;
        repeat (5) begin
            tick();
            extra += int'(done);
        end
        checkOutput("ign_extra_done", extra, 0);

        $display("[TB] abort after two groups");
        applyStimulus(fill(10), fill(3), 1'b0, 1'b0);
        tick();
        tick();
        clr_sub = 1'b1;
        tick();
        clr_sub = 1'b0;
        checkOutput("clr_busy", longint'(busy), 0);
        checkOutput("clr_done", longint'(done), 0);
        checkOutput("clr_w00", el(w_flat, 0), 7);
        checkOutput("clr_w13", el(w_flat, 7), 7);
        checkOutput("clr_w20", el(w_flat, 8), 507);
        checkOutput("clr_w33", el(w_flat, 15), 507);
        extra = 0;
        repeat (5) begin
            tick();
            extra += int'(done);
        end
        checkOutput("clr_no_done", extra, 0);

        $display("[TB] back-to-back start in done cycle");
        applyStimulus(fill(1), fill(2), 1'b1, 1'b0);
        waitDone(4, "b2b1");
        checkOutput("b2b1_w00", el(w_flat, 0), 3);
        applyStimulus(fill(5), fill(5), 1'b0, 1'b0);
        checkOutput("b2b2_busy", longint'(busy), 1);
        checkOutput("b2b2_done", longint'(done), 0);
        waitDone(4, "b2b2");
        checkOutput("b2b2_w00", el(w_flat, 0), 0);

        $display("[TB] async reset mid-run");
        applyStimulus(put('0, 0, MAXV), put('0, 0, 1), 1'b1, 1'b1);
        tick();
        tick();
        checkOutput("pre_rst_ovf", longint'(ovf), 1);
        checkOutput("pre_rst_w00", el(w_flat, 0), 33554431);
        #2;
        rstn_sub = 1'b0;
        #1;
        checkVec("arst_w", w_flat, '0);
        checkOutput("arst_busy", longint'(busy), 0);
        checkOutput("arst_done", longint'(done), 0);
        checkOutput("arst_ovf", longint'(ovf), 0);
        tick();
        tick();
        rstn_sub = 1'b1;
        applyStimulus(fill(100), fill(30), 1'b0, 1'b0);
        waitDone(4, "post_rst");
        checkOutput("post_rst_w21", el(w_flat, 9), 70);
        tick();

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
